// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT source-side beat stream plus peak result handshake.
interface fft_peak_detect_if #(
    parameter int DATA_W = 14,
    parameter int IDX_W  = 10
);
    logic                       source_valid;
    logic                       source_ready;
    logic                       source_sop;
    logic                       source_eop;
    logic signed [DATA_W-1:0]   source_real;
    logic signed [DATA_W-1:0]   source_imag;
    logic                       peak_valid;
    logic                       peak_ready;
    logic [IDX_W-1:0]           peak_bin;
    logic [2*DATA_W-1:0]        peak_mag;
    modport master (
        output source_valid, source_sop, source_eop, source_real, source_imag, peak_ready,
        input  source_ready, peak_valid, peak_bin, peak_mag
    );
    modport slave (
        input  source_valid, source_sop, source_eop, source_real, source_imag, peak_ready,
        output source_ready, peak_valid, peak_bin, peak_mag
    );
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame |X[k]|^2 peak search over FFT output bins,
// with SOP/EOP framing enforcement and a saturating violation count.
module fft_peak_detect #(
    parameter int DATA_W  = 14,
    parameter int FFT_PTS = 1024,
    parameter int IDX_W   = 10,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    fft_peak_detect_if.slave  bus,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);
    localparam int MAG_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FFT_PTS - 1);
    typedef enum logic [1:0] {HUNT, FRAME, DRAIN, HOLD} state_t;
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d, in_bin;
    logic [1:0]              drain_q, drain_d;
    logic                    tag_q, tag_d, acc, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    err_pulse_q;
    logic signed [MAG_W-1:0] re_x, im_x;
    logic                    s1_v_q, s1_v_d, s1_tag_q, s1_tag_d;
    logic [IDX_W-1:0]        s1_bin_q, s1_bin_d;
    logic [MAG_W-1:0]        s1_re2_q, s1_re2_d, s1_im2_q, s1_im2_d;
    logic                    s2_v_q, s2_v_d, s2_tag_q, s2_tag_d;
    logic [IDX_W-1:0]        s2_bin_q, s2_bin_d;
    logic [MAG_W-1:0]        s2_mag_q, s2_mag_d;
    logic [IDX_W-1:0]        max_bin_q, max_bin_d;
    logic [MAG_W-1:0]        max_mag_q, max_mag_d;
    logic                    pk_v_q, pk_v_d;
    logic [IDX_W-1:0]        pk_bin_q, pk_bin_d;
    logic [MAG_W-1:0]        pk_mag_q, pk_mag_d;
    assign bus.source_ready = reset_n && (state_q == HUNT || state_q == FRAME);
    assign bus.peak_valid   = pk_v_q;
    assign bus.peak_bin     = pk_bin_q;
    assign bus.peak_mag     = pk_mag_q;
    assign err_pulse        = err_pulse_q;
    assign err_cnt          = err_cnt_q;
    always_comb begin
        acc      = bus.source_valid && bus.source_ready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        err_d    = 1'b0;
        in_bin   = '0;
        pk_v_d   = pk_v_q;
        pk_bin_d = pk_bin_q;
        pk_mag_d = pk_mag_q;
        drain_d  = (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
        case (state_q)
            HUNT: if (acc) begin
                if (bus.source_sop) begin
                    state_d = FRAME;
                    cnt_d   = IDX_W'(1);
                    tag_d   = ~tag_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            FRAME: if (acc) begin
                if (bus.source_sop) begin
                    err_d = 1'b1;
                    cnt_d = IDX_W'(1);
                    tag_d = ~tag_q;
                end else begin
                    in_bin = cnt_q;
                    cnt_d  = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST || bus.source_eop) begin
                        state_d = (cnt_q == LAST && bus.source_eop) ? DRAIN : HUNT;
                        err_d   = !(cnt_q == LAST && bus.source_eop);
                    end
                end
            end
            DRAIN: if (drain_q == 2'd2) begin
                state_d  = HOLD;
                pk_v_d   = 1'b1;
                pk_bin_d = max_bin_q;
                pk_mag_d = max_mag_q;
            end
            HOLD: if (bus.peak_ready) begin
                state_d = HUNT;
                pk_v_d  = 1'b0;
            end
            default: state_d = HUNT;
        endcase
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        re_x      = MAG_W'(bus.source_real);
        im_x      = MAG_W'(bus.source_imag);
        // Stray HUNT beats never enter; the tag retires beats of an aborted frame.
        s1_v_d    = acc && (state_q == FRAME || bus.source_sop);
        s1_tag_d  = tag_d;
        s1_bin_d  = in_bin;
        s1_re2_d  = re_x * re_x;
        s1_im2_d  = im_x * im_x;
        s2_v_d    = s1_v_q;
        s2_tag_d  = s1_tag_q;
        s2_bin_d  = s1_bin_q;
        s2_mag_d  = s1_re2_q + s1_im2_q;
        max_bin_d = max_bin_q;
        max_mag_d = max_mag_q;
        if (s2_v_q && s2_tag_q == tag_q) begin
            if (s2_bin_q == '0) begin
                max_bin_d = '0;
                max_mag_d = SKIP_DC ? '0 : s2_mag_q;
            end else if (s2_mag_q > max_mag_q) begin
                max_bin_d = s2_bin_q;
                max_mag_d = s2_mag_q;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            drain_q     <= '0;
            tag_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            s1_v_q      <= 1'b0;
            s1_tag_q    <= 1'b0;
            s1_bin_q    <= '0;
            s1_re2_q    <= '0;
            s1_im2_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_tag_q    <= 1'b0;
            s2_bin_q    <= '0;
            s2_mag_q    <= '0;
            max_bin_q   <= '0;
            max_mag_q   <= '0;
            pk_v_q      <= 1'b0;
            pk_bin_q    <= '0;
            pk_mag_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            tag_q       <= tag_d;
            err_pulse_q <= err_d;
            err_cnt_q   <= err_cnt_d;
            s1_v_q      <= s1_v_d;
            s1_tag_q    <= s1_tag_d;
            s1_bin_q    <= s1_bin_d;
            s1_re2_q    <= s1_re2_d;
            s1_im2_q    <= s1_im2_d;
            s2_v_q      <= s2_v_d;
            s2_tag_q    <= s2_tag_d;
            s2_bin_q    <= s2_bin_d;
            s2_mag_q    <= s2_mag_d;
            max_bin_q   <= max_bin_d;
            max_mag_q   <= max_mag_d;
            pk_v_q      <= pk_v_d;
            pk_bin_q    <= pk_bin_d;
            pk_mag_q    <= pk_mag_d;
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: scoreboard bench driving two DUTs (SKIP_DC=1 and SKIP_DC=0) in lockstep.
module tb_fft_peak_detect;
    localparam int N = 1024;
    typedef struct packed {
        logic [9:0]  b0;
        logic [27:0] m0;
        logic [9:0]  b1;
        logic [27:0] m1;
    } res_t;
    logic       clk = 1'b0, reset_n = 1'b1;
    logic       e0, e1;
    logic [7:0] c0, c1;
    int         checks = 0, errors = 0;
    int         re_a[N], im_a[N];
    res_t       sb[$];
    always #5 clk = ~clk;
    fft_peak_detect_if #(.DATA_W(14), .IDX_W(10)) b0 ();
    fft_peak_detect_if #(.DATA_W(14), .IDX_W(10)) b1 ();
    assign b1.source_valid = b0.source_valid;
    assign b1.source_sop   = b0.source_sop;
    assign b1.source_eop   = b0.source_eop;
    assign b1.source_real  = b0.source_real;
    assign b1.source_imag  = b0.source_imag;
    assign b1.peak_ready   = b0.peak_ready;
    fft_peak_detect #(.DATA_W(14), .FFT_PTS(N), .IDX_W(10), .SKIP_DC(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0), .err_pulse(e0), .err_cnt(c0));
    fft_peak_detect #(.DATA_W(14), .FFT_PTS(N), .IDX_W(10), .SKIP_DC(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1), .err_pulse(e1), .err_cnt(c1));

    function automatic res_t model();
        res_t r = '0;
        longint m;
        for (int k = 0; k < N; k++) begin
            m = longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k];
            if (k != 0 && m > longint'(r.m0)) begin r.b0 = 10'(k); r.m0 = 28'(m); end
            if (m > longint'(r.m1)) begin r.b1 = 10'(k); r.m1 = 28'(m); end
        end
        return r;
    endfunction

    task automatic fill(input int amp);
        for (int k = 0; k < N; k++) begin
            re_a[k] = (amp == 0) ? 0 : int'($urandom_range(0, 2 * amp)) - amp;
            im_a[k] = (amp == 0) ? 0 : int'($urandom_range(0, 2 * amp)) - amp;
        end
    endtask

    task automatic drive_beats(input int first, input int n, input bit sop0, input bit eopn);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            b0.source_valid = 1'b1;
            b0.source_sop   = sop0 && i == 0;
            b0.source_eop   = eopn && i == n - 1;
            b0.source_real  = 14'(re_a[first + i]);
            b0.source_imag  = 14'(im_a[first + i]);
            while (!b0.source_ready && w < 100) begin @(posedge clk); #1; w++; end
            if (!b0.source_ready) begin
                checks++; errors++;
                $display("FAIL drive_stall beat %0d: source_ready=0 after 100 cycles, expected 1", i);
            end
            @(posedge clk); #1;
        end
        b0.source_valid = 1'b0;
        b0.source_sop   = 1'b0;
        b0.source_eop   = 1'b0;
    endtask

    task automatic collect(output res_t obs, output int lat);
        lat = 0;
        while (!b0.peak_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        obs = {b0.peak_bin, b0.peak_mag, b1.peak_bin, b1.peak_mag};
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #12;
        checks++;
        if ({b0.source_ready, b0.peak_valid, b0.peak_bin, b0.peak_mag, e0, c0} !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b pv=%b bin=%0d mag=%0d err=%b cnt=%0d, expected all 0",
                     b0.source_ready, b0.peak_valid, b0.peak_bin, b0.peak_mag, e0, c0);
        end
        @(negedge clk) reset_n = 1'b1;
        #1;
        checks++;
        if (b0.source_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", b0.source_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_tone();
        res_t exp, obs;
        int lat;
        fill(0);
        re_a[37] = 1000;
        sb.push_back(model());
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL tone_latency: peak_valid %0d edges after eop edge, expected 3", lat); end
        checks++;
        if ({obs.b0, obs.m0} !== {exp.b0, exp.m0}) begin errors++; $display("FAIL tone_dut0: bin %0d mag %0d, expected bin %0d mag %0d", obs.b0, obs.m0, exp.b0, exp.m0); end
        checks++;
        if ({obs.b1, obs.m1} !== {exp.b1, exp.m1}) begin errors++; $display("FAIL tone_dut1: bin %0d mag %0d, expected bin %0d mag %0d", obs.b1, obs.m1, exp.b1, exp.m1); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        res_t exp, obs;
        int lat;
        fill(100);
        re_a[5] = -8192; im_a[5] = -8192;
        re_a[9] = -8192; im_a[9] = -8192;
        sb.push_back(model());
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if ({obs.b0, obs.m0} !== {exp.b0, exp.m0}) begin errors++; $display("FAIL tie_dut0: bin %0d mag %0d, expected bin %0d mag %0d", obs.b0, obs.m0, exp.b0, exp.m0); end
        checks++;
        if ({obs.b1, obs.m1} !== {10'd5, 28'd134217728}) begin errors++; $display("FAIL tie_dut1: bin %0d mag %0d, expected bin 5 mag 134217728", obs.b1, obs.m1); end
        @(posedge clk); #1;
    endtask

    task automatic test_dc();
        res_t exp, obs;
        int lat;
        fill(0);
        re_a[0] = 8191; im_a[0] = 8191;
        re_a[200] = 3; im_a[200] = 4;
        sb.push_back(model());
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if ({obs.b0, obs.m0} !== {10'd200, 28'd25}) begin errors++; $display("FAIL dc_skip: bin %0d mag %0d, expected bin 200 mag 25", obs.b0, obs.m0); end
        checks++;
        if ({obs.b1, obs.m1} !== {exp.b1, exp.m1}) begin errors++; $display("FAIL dc_keep: bin %0d mag %0d, expected bin %0d mag %0d", obs.b1, obs.m1, exp.b1, exp.m1); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        res_t exp, obs;
        int lat;
        fill(50);
        re_a[777] = -2000;
        sb.push_back(model());
        b0.peak_ready = 1'b0;
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (b0.source_ready !== 1'b0 || b0.peak_valid !== 1'b1 || {b0.peak_bin, b0.peak_mag} !== {obs.b0, obs.m0}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: rdy=%b pv=%b bin=%0d mag=%0d, expected rdy 0 pv 1 bin %0d mag %0d",
                         i, b0.source_ready, b0.peak_valid, b0.peak_bin, b0.peak_mag, obs.b0, obs.m0);
            end
        end
        exp = sb.pop_front();
        checks++;
        if ({obs.b0, obs.m0} !== {exp.b0, exp.m0}) begin errors++; $display("FAIL bp_dut0: bin %0d mag %0d, expected bin %0d mag %0d", obs.b0, obs.m0, exp.b0, exp.m0); end
        b0.peak_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (b0.peak_valid !== 1'b0 || b0.source_ready !== 1'b1) begin errors++; $display("FAIL bp_release: pv=%b rdy=%b, expected pv 0 rdy 1", b0.peak_valid, b0.source_ready); end
    endtask

    task automatic test_back_to_back();
        res_t exp, obs;
        int lat;
        for (int f = 0; f < 2; f++) begin
            fill(300);
            im_a[100 + 300 * f] = 4000;
            sb.push_back(model());
            drive_beats(0, N, 1'b1, 1'b1);
            collect(obs, lat);
            exp = sb.pop_front();
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL b2b_latency f%0d: %0d edges, expected 3", f, lat); end
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b_result f%0d: got %h expected %h", f, obs, exp); end
            @(posedge clk); #1;
            checks++;
            if (b0.source_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready f%0d: got %b expected 1", f, b0.source_ready); end
        end
    endtask

    task automatic test_framing();
        res_t exp, obs;
        int lat;
        bit seen;
        fill(20);
        drive_beats(0, 501, 1'b1, 1'b1);
        checks++;
        if (e0 !== 1'b1 || c0 !== 8'd1) begin errors++; $display("FAIL early_eop: err_pulse=%b err_cnt=%0d, expected 1 and 1", e0, c0); end
        @(posedge clk); #1;
        checks++;
        if (e0 !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", e0); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin seen |= b0.peak_valid; @(posedge clk); #1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL early_eop_result: peak_valid seen %b, expected 0", seen); end
        drive_beats(0, 1, 1'b0, 1'b0);
        checks++;
        if (c0 !== 8'd2) begin errors++; $display("FAIL stray_beat: err_cnt %0d expected 2", c0); end
        re_a[50] = 5000;
        drive_beats(0, 100, 1'b1, 1'b0);
        fill(20);
        re_a[700] = 3000;
        sb.push_back(model());
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (c0 !== 8'd3) begin errors++; $display("FAIL mid_sop_cnt: err_cnt %0d expected 3", c0); end
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL mid_sop_result: got %h expected %h", obs, exp); end
        @(posedge clk); #1;
        drive_beats(0, 300, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (c0 !== 8'd255) begin errors++; $display("FAIL err_saturate: err_cnt %0d expected 255", c0); end
    endtask

    task automatic test_reset_mid();
        res_t exp, obs;
        int lat;
        fill(20);
        drive_beats(0, 600, 1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        checks++;
        if ({b0.source_ready, b0.peak_valid, b0.peak_bin, b0.peak_mag, e0, c0} !== '0) begin
            errors++;
            $display("FAIL reset_mid_values: rdy=%b pv=%b bin=%0d mag=%0d err=%b cnt=%0d, expected all 0",
                     b0.source_ready, b0.peak_valid, b0.peak_bin, b0.peak_mag, e0, c0);
        end
        @(negedge clk) reset_n = 1'b1;
        #1;
        checks++;
        if (b0.source_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b expected 1", b0.source_ready); end
        @(posedge clk); #1;
        fill(80);
        re_a[1023] = 1500;
        sb.push_back(model());
        drive_beats(0, N, 1'b1, 1'b1);
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_result: got %h expected %h", obs, exp); end
        @(posedge clk); #1;
    endtask

    initial begin
        b0.source_valid = 1'b0;
        b0.source_sop   = 1'b0;
        b0.source_eop   = 1'b0;
        b0.source_real  = '0;
        b0.source_imag  = '0;
        b0.peak_ready   = 1'b1;
        test_reset();
        test_tone();
        test_tie();
        test_dc();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
